vec_seq_capture: RTL and testbench



---
 rtl/vec_seq_pkg.sv | 23 ++
 rtl/sig_misr.sv | 42 ++++
 rtl/vec_seq_capture.sv | 172 +++++++++++++++++
 tb/tb_vec_seq_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// -----------------------------------------------------------------------------
// vec_seq_pkg
// Shared definitions for the vector sequencer / response capture stage:
// FSM state encoding, default vector width, default signature polynomial and
// the feedback taps of the optional LFSR vector source (VEC_LFSR_GEN_EN).
// No ports.
// -----------------------------------------------------------------------------
package vec_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int          DEF_NIN      = 10;
    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;

    // x^10 + x^7 + 1: feedback from bits 9 and 6, shifted in at bit 0.
    localparam logic [DEF_NIN-1:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/sig_misr.sv
// -----------------------------------------------------------------------------
// sig_misr
// Serial signature register. Each enabled cycle shifts left by one and XORs in
// SIG_POLY when the outgoing MSB differs from the serial input bit.
//
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (clears signature)
//   clr   in   synchronous clear, has priority over en
//   en    in   shift/compact one bit this cycle
//   din   in   serial data bit
//   sig   out  current signature (SIG_W bits)
// -----------------------------------------------------------------------------
module sig_misr
    import vec_seq_pkg::*;
#(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic fb;

    assign fb = sig[SIG_W-1] ^ din;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
        end
    end

endmodule

// File: rtl/vec_seq_capture.sv
// -----------------------------------------------------------------------------
// vec_seq_capture
// Drives a sequence of input vectors onto a combinational cone, waits SETTLE
// cycles per vector, samples the cone output and compacts the responses into a
// serial signature plus a count of ones. Start/done handshake to the test
// controller.
//
// Build option: define VEC_LFSR_GEN_EN to source vectors from a NIN-bit
// Fibonacci LFSR (seed 1) instead of the default binary counter (vec = index).
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   launch a run (only looked at in IDLE)
//   num_vec   in   number of vectors to apply, latched at start
//   vec       out  cone inputs a..j (bit NIN-1 = a)
//   o_in      in   cone output
//   busy      out  high while vectors are being applied
//   done      out  one-cycle pulse at end of run
//   sig       out  response signature, stable from done until next start
//   ones_cnt  out  number of samples that saw o_in = 1
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_SETTLE | current vector applied, settle down-counter running
// ST_SAMPLE | last cycle of the vector; o_in captured at the closing edge
// ST_DONE   | done pulse, back to IDLE next cycle
// -----------------------------------------------------------------------------
module vec_seq_capture
    import vec_seq_pkg::*;
#(
    parameter int               NIN      = DEF_NIN,
    parameter int               SETTLE   = 1,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NIN:0]     num_vec,
    output logic [NIN-1:0]   vec,
    input  logic             o_in,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic [NIN:0]     ones_cnt
);

    // Down-counter reload: reaching zero in SETTLE means the next cycle is
    // the SAMPLE cycle, giving SETTLE+1 cycles per vector in total.
    localparam logic [3:0] SETTLE_LD   = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_t     FIRST_PHASE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

`ifdef VEC_LFSR_GEN_EN
    localparam logic [NIN-1:0] VEC_INIT = NIN'(1);
`else
    localparam logic [NIN-1:0] VEC_INIT = '0;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      settle_cnt;
    logic [NIN:0]    index;
    logic [NIN:0]    index_inc;
    logic [NIN:0]    num_lat;
    logic [NIN-1:0]  vec_next;
    logic            run_start;
    logic            sample_en;
    logic            load_settle;
    logic            last_sample;

    assign index_inc   = index + (NIN+1)'(1);
    assign last_sample = (index_inc == num_lat);

`ifdef VEC_LFSR_GEN_EN
    assign vec_next = {vec[NIN-2:0], ^(vec & NIN'(LFSR_TAPS))};
`else
    assign vec_next = index_inc[NIN-1:0];
`endif

    always_comb begin
        state_nxt   = state;
        run_start   = 1'b0;
        sample_en   = 1'b0;
        load_settle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    run_start = 1'b1;
                    if (num_vec == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt   = FIRST_PHASE;
                        load_settle = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                if (last_sample) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt   = FIRST_PHASE;
                    load_settle = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            index      <= '0;
            num_lat    <= '0;
            vec        <= '0;
            ones_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (load_settle) begin
                settle_cnt <= SETTLE_LD;
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (run_start) begin
                num_lat  <= num_vec;
                index    <= '0;
                ones_cnt <= '0;
                vec      <= VEC_INIT;
            end else if (sample_en) begin
                index <= index_inc;
                if (o_in) begin
                    ones_cnt <= ones_cnt + (NIN+1)'(1);
                end
                // On the final sample vec is left alone so it holds after the run.
                if (!last_sample) begin
                    vec <= vec_next;
                end
            end
        end
    end

    sig_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_sig_misr (
        .clk (clk),
        .rst (rst),
        .clr (run_start),
        .en  (sample_en),
        .din (o_in),
        .sig (sig)
    );

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_vec_seq_capture.sv
module tb_vec_seq_capture;

    localparam int          NIN    = 10;
    localparam int          SETTLE = 1;
    localparam int          SIG_W  = 16;
    localparam logic [15:0] POLY   = 16'h1021;
    localparam int          HOLD   = SETTLE + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [NIN:0]     num_vec = '0;
    logic [NIN-1:0]   vec;
    logic             o_in;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] sig;
    logic [NIN:0]     ones_cnt;

    int omode = 0;   // 0: o_in tied 0, 1: tied 1, 2: cone model
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [SIG_W-1:0] sig;
        logic [NIN:0]     ones;
    } res_t;

    res_t             rq[$];
    logic [NIN-1:0]   vq[$];
    logic [SIG_W-1:0] sq[$];

    vec_seq_capture #(
        .NIN      (NIN),
        .SETTLE   (SETTLE),
        .SIG_W    (SIG_W),
        .SIG_POLY (POLY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .vec      (vec),
        .o_in     (o_in),
        .busy     (busy),
        .done     (done),
        .sig      (sig),
        .ones_cnt (ones_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic cone(input logic [NIN-1:0] v);
        logic a, b, c, d, e, f, g, h, i, j;
        {a, b, c, d, e, f, g, h, i, j} = v;
        return (a & b) ^ (c | d) ^ (e & ~f) ^ ((g ^ h) & (i | j));
    endfunction

    function automatic logic exp_o(input logic [NIN-1:0] v);
        if (omode == 0) return 1'b0;
        if (omode == 1) return 1'b1;
        return cone(v);
    endfunction

    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] s, input logic b);
        logic [SIG_W-1:0] t;
        t = s << 1;
        if (s[SIG_W-1] ^ b) t = t ^ POLY;
        return t;
    endfunction

    always_comb o_in = exp_o(vec);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic run(input int n, input bit glitch, output logic [SIG_W-1:0] sig_out);
        logic [SIG_W-1:0] s;
        logic [NIN:0]     ones;
        logic [NIN-1:0]   v;
        logic             b;
        res_t             r;
        int               c;
        bit               fin;

        s    = '0;
        ones = '0;
`ifdef VEC_LFSR_GEN_EN
        v = NIN'(1);
`else
        v = '0;
`endif
        for (int i = 0; i < n; i++) begin
`ifndef VEC_LFSR_GEN_EN
            v = NIN'(i);
`endif
            b = exp_o(v);
            s = sig_step(s, b);
            ones = ones + (NIN+1)'(b);
            for (int h = 0; h < HOLD; h++) vq.push_back(v);
            sq.push_back(s);
`ifdef VEC_LFSR_GEN_EN
            v = {v[NIN-2:0], v[9] ^ v[6]};
`endif
        end
        r.sig  = s;
        r.ones = ones;
        rq.push_back(r);
        sig_out = s;

        @(negedge clk);
        num_vec = (NIN+1)'(n);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c     = 0;
        fin   = 0;
        while (!fin) begin
            if (done) begin
                chk("done_time", 32'(c), 32'(n * HOLD));
                chk("busy_at_done", 32'(busy), 32'd0);
                r = rq.pop_front();
                chk("sig_final", 32'(sig), 32'(r.sig));
                chk("ones_final", 32'(ones_cnt), 32'(r.ones));
                if (sq.size() > 0) chk("sig_last_step", 32'(sig), 32'(sq.pop_front()));
                chk("vec_left", 32'(vq.size()), 32'd0);
                start = glitch;
                @(negedge clk);
                start = 1'b0;
                chk("done_pulse", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                @(negedge clk);
                chk("no_relaunch", 32'(busy), 32'd0);
                fin = 1;
            end else if (c > n * HOLD + 4) begin
                n_chk++;
                n_err++;
                $display("FAIL done_timeout n=%0d cycles=%0d", n, c);
                vq.delete();
                sq.delete();
                rq.delete();
                start = 1'b0;
                fin = 1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
                chk("vec_expected", 32'(vq.size() > 0), 32'd1);
                if (vq.size() > 0) chk("vec", 32'(vec), 32'(vq.pop_front()));
                if (c > 0 && (c % HOLD) == 0 && sq.size() > 0)
                    chk("sig_step", 32'(sig), 32'(sq.pop_front()));
                if (glitch) begin
                    start   = ($urandom_range(0, 3) == 0);
                    num_vec = (NIN+1)'($urandom);
                end
                @(negedge clk);
                c++;
            end
        end
    endtask

    initial begin
        logic [SIG_W-1:0] s_ref;
        logic [SIG_W-1:0] s_tmp;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_ones", 32'(ones_cnt), 32'd0);
        rst = 1'b0;

        // zero-length run
        omode = 0;
        run(0, 1'b0, s_tmp);
        chk("t1_sig", 32'(sig), 32'h0);
        chk("t1_ones", 32'(ones_cnt), 32'd0);

        // o_in tied low
        omode = 0;
        run(4, 1'b0, s_tmp);
        chk("t2_sig", 32'(sig), 32'h0);
        chk("t2_ones", 32'(ones_cnt), 32'd0);
`ifndef VEC_LFSR_GEN_EN
        chk("t2_vec_hold", 32'(vec), 32'd3);
`endif

        // o_in tied high
        omode = 1;
        run(2, 1'b0, s_tmp);
        chk("t3_sig", 32'(sig), 32'h3063);
        chk("t3_ones", 32'(ones_cnt), 32'd2);

`ifdef VEC_LFSR_GEN_EN
        omode = 2;
        run(3, 1'b1, s_tmp);
        chk("t6_vec_hold", 32'(vec), 32'h004);
`endif

        // full exhaustive sweep through the cone, with stray start pulses
        omode = 2;
        run(1024, 1'b1, s_tmp);

        // reference run, then abort a run at index 5 with reset
        omode = 2;
        run(20, 1'b0, s_ref);
        @(negedge clk);
        num_vec = 11'd20;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5 * HOLD) @(negedge clk);
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_vec", 32'(vec), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_sig", 32'(sig), 32'd0);
        chk("t5_rst_ones", 32'(ones_cnt), 32'd0);
        rst = 1'b0;
        run(20, 1'b0, s_tmp);
        chk("t5_same_sig", 32'(sig), 32'(s_ref));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
